aes_state_array_ctrl: RTL
=========================

// Module: aes_state_array_ctrl
// PURPOSE
// Parametrised AES state array with its own command FSM; successor to the fixed byte-serial state register.
// Holds the 16-byte state and streams it LANES bytes/cycle through an external S-box and round-key XOR.
// Performs ShiftRows and MixColumns as single-cycle full-state permutations, forward or inverse.
// Sits between the host load/unload streams, the S-box unit and the key schedule; a round controller drives op_*.
// PARAMETERS
// LANES   4  bytes per beat; legal values 1, 2, 4; BEATS = 16/LANES
// INV_EN  1  1 = inverse ShiftRows/MixColumns datapath present; 0 = forward only
// PORTS
// clk        in   1         rising-edge clock
// rst_n      in   1         asynchronous active-low reset
// op_valid   in   1         command valid
// op_ready   out  1         1 only in IDLE
// op_code    in   3         0 LOAD, 1 SUB, 2 ARK, 3 SR, 4 MC, 5 UNLOAD; 6-7 illegal
// op_inv     in   1         inverse variant for SR/MC (ignored for other ops)
// op_err     out  1         one-cycle pulse on rejected command
// busy       out  1         FSM not in IDLE
// in_valid   in   1         LOAD beat valid
// in_ready   out  1         high only in LOAD
// in_data    in   8*LANES   LOAD beat; lane k = bits [8k+7:8k]
// key_valid  in   1         ARK key beat valid
// key_ready  out  1         high only in ARK
// key_data   in   8*LANES   round-key beat, same lane order
// sbox_in    out  8*LANES   head bytes to external S-box (0 outside SUB)
// sbox_out   in   8*LANES   S-box result, combinational same cycle
// out_valid  out  1         UNLOAD beat valid
// out_ready  in   1         UNLOAD beat accepted
// out_data   out  8*LANES   UNLOAD beat (0 when out_valid=0)
// BEHAVIOUR
// - Byte order: state byte i = row i%4, col i/4; beat b, lane k carries byte b*LANES+k.
// - Storage is a rotating array: a streamed beat consumes bytes 0..LANES-1, shifts all left by LANES, writes result at 16-LANES..15.
// - Reset: state all 0, FSM IDLE, beat counter 0; op_ready=1, all other outputs 0.
// - FSM states IDLE, LOAD, SUB, ARK, UNLOAD. Command accepted on op_valid&&op_ready.
// - LOAD: on in_valid, write in_data at tail; BEATS accepted beats -> IDLE. Bubbles allowed.
// - SUB: sbox_in = head bytes, sbox_out written at tail, one beat/cycle, no stall; BEATS cycles -> IDLE.
// - ARK: on key_valid, tail <= head ^ key_data; key_valid low stalls; BEATS beats -> IDLE.
// - UNLOAD: out_data = head; on out_valid&&out_ready rotate head to tail (state preserved); BEATS beats -> IDLE.
// - SR, MC: stay in IDLE, update whole state on the accept edge, op_ready stays 1 (back-to-back ops allowed).
// - SR fwd: row r rotated left r; inv: right r. MC fwd matrix {02,03,01,01}, inv {0e,0b,0d,09}, GF(2^8) mod 0x11b.
// - op_inv=1 with INV_EN=0, or op_code 6/7: command consumed, state unchanged, op_err=1 the next cycle.
// - Latency: last streamed beat -> IDLE (op_ready=1) the next cycle; beat counter wraps to 0.
// - Handshake signals for inactive streams are 0; in_valid/key_valid/out_ready outside their state are ignored.
// - rst_n low mid-operation aborts immediately: state cleared, counter 0, IDLE; no partial beats retained.
// TESTING
// - LOAD 193de3be a0f4e22b 9ac68d2a e9f84808 (FIPS-197 App.B), SUB with reference S-box -> state d42711ae e0bf98f1 b8b45de5 1e415230.
// - SR fwd on that -> d4bf5d30 e0b452ae b84111f1 1e2798e5; then MC fwd -> 04 66 81 e5 e0 cb 19 9a 48 f8 d3 7a 28 06 26 4c.
// - ARK key a0fafe17 88542cb1 23a33939 2a6c7605 -> a49c7ff2 689f352b 6b5bea43 026a5049; UNLOAD returns those bytes in order.
// - INV_EN=1: MC inv then SR inv from 04 66 81 e5... restores d42711ae...; INV_EN=0 op_inv -> op_err pulse, state unchanged.
// - UNLOAD with out_ready toggled 1,0,0,1 and ARK with key_valid gaps -> no beat lost/duplicated; repeat for LANES 1, 2, 4.
// - rst_n low during LOAD beat 2 -> all outputs 0, IDLE; a fresh LOAD+UNLOAD returns the new data only.

Source files
------------

// File: rtl/aes_state_array_ctrl.sv
// aes_state_array_ctrl
//   16-byte AES state held as a rotating byte array with its own command FSM.
//   Streamed ops (LOAD, SUB, ARK, UNLOAD) move LANES bytes per beat. Each beat
//   takes the head bytes 0..LANES-1, shifts the array left by LANES and writes
//   the result at the tail. SR and MC are single-cycle whole-state
//   permutations, applied on the command accept edge.
// Ports
//   clk, rst_n                   clock, async active-low reset
//   op_valid/op_ready/op_code    command handshake (0 LOAD 1 SUB 2 ARK 3 SR 4 MC 5 UNLOAD)
//   op_inv, op_err               inverse select for SR/MC, one-cycle reject pulse
//   busy                         FSM not idle
//   in_valid/in_ready/in_data    LOAD beat stream
//   key_valid/key_ready/key_data ARK round-key beat stream
//   sbox_in/sbox_out             head bytes out, combinational S-box result back
//   out_valid/out_ready/out_data UNLOAD beat stream
module aes_state_array_ctrl #(
    parameter int LANES  = 4,
    parameter int INV_EN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [2:0]         op_code,
    input  logic               op_inv,
    output logic               op_err,
    output logic               busy,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic               key_valid,
    output logic               key_ready,
    input  logic [8*LANES-1:0] key_data,
    output logic [8*LANES-1:0] sbox_in,
    input  logic [8*LANES-1:0] sbox_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data
);
    localparam int BEATS = 16 / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, SUB, ARK, UNLOAD} fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [15:0][7:0] st_q, st_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [LANES-1:0][7:0] head, tail, in_b, key_b, sbo_b;
    logic [15:0][7:0]      st_rot, sr_f, sr_i, mc_f, mc_i;
    logic                  fire, last, inv_ok;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) multiply by a small constant (coefficients all fit in 4 bits)
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    assign head  = st_q[LANES-1:0];
    assign in_b  = in_data;
    assign key_b = key_data;
    assign sbo_b = sbox_out;

    always_comb begin
        fire = 1'b0;
        tail = head;
        case (fsm_q)
            LOAD:    begin fire = in_valid;  tail = in_b;         end
            SUB:     begin fire = 1'b1;      tail = sbo_b;        end
            ARK:     begin fire = key_valid; tail = head ^ key_b; end
            UNLOAD:  begin fire = out_ready; tail = head;         end
            default: ;
        endcase
    end

    assign st_rot = {tail, st_q[15:LANES]};
    assign last   = (cnt_q == CW'(BEATS - 1));
    assign inv_ok = (INV_EN != 0);

    // byte index i = row + 4*col
    always_comb begin
        sr_f = '0;
        sr_i = '0;
        mc_f = '0;
        mc_i = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr_f[r+4*c] = st_q[r+4*((c+r)%4)];
                sr_i[r+4*c] = st_q[r+4*((c+4-r)%4)];
                mc_f[r+4*c] = gm(st_q[4*c+r], 4'h2) ^ gm(st_q[4*c+(r+1)%4], 4'h3)
                            ^ st_q[4*c+(r+2)%4] ^ st_q[4*c+(r+3)%4];
                mc_i[r+4*c] = gm(st_q[4*c+r], 4'he) ^ gm(st_q[4*c+(r+1)%4], 4'hb)
                            ^ gm(st_q[4*c+(r+2)%4], 4'hd) ^ gm(st_q[4*c+(r+3)%4], 4'h9);
            end
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        st_d  = st_q;
        cnt_d = cnt_q;
        err_d = 1'b0;
        if (fsm_q == IDLE) begin
            if (op_valid) begin
                case (op_code)
                    3'd0: fsm_d = LOAD;
                    3'd1: fsm_d = SUB;
                    3'd2: fsm_d = ARK;
                    3'd5: fsm_d = UNLOAD;
                    3'd3: begin
                        if (op_inv && !inv_ok) err_d = 1'b1;
                        else                   st_d  = op_inv ? sr_i : sr_f;
                    end
                    3'd4: begin
                        if (op_inv && !inv_ok) err_d = 1'b1;
                        else                   st_d  = op_inv ? mc_i : mc_f;
                    end
                    default: err_d = 1'b1;
                endcase
            end
        end else if (fire) begin
            st_d = st_rot;
            if (last) begin
                cnt_d = '0;
                fsm_d = IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= IDLE;
            st_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            fsm_q <= fsm_d;
            st_q  <= st_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign op_ready  = (fsm_q == IDLE);
    assign busy      = (fsm_q != IDLE);
    assign in_ready  = (fsm_q == LOAD);
    assign key_ready = (fsm_q == ARK);
    assign out_valid = (fsm_q == UNLOAD);
    assign op_err    = err_q;
    assign sbox_in   = (fsm_q == SUB) ? head : '0;
    assign out_data  = out_valid ? head : '0;

endmodule
